// File: rtl/bus_responder_pkg.sv
// Shared bus-map constants for the CPU memory bus target: I/O page, register offsets,
// STATUS/CTRL bit positions and the address-region decoder.
package bus_responder_pkg;

    localparam logic [7:0] IO_PAGE_DEFAULT = 8'hFF;

    localparam logic [7:0] IO_STATUS = 8'h00;
    localparam logic [7:0] IO_RXDATA = 8'h01;
    localparam logic [7:0] IO_TXDATA = 8'h02;
    localparam logic [7:0] IO_CTRL   = 8'h03;

    localparam int ST_RX_VALID = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_TX_EMPTY = 3;

    localparam int CTRL_OVF_CLR = 0;
    localparam int CTRL_IRQ_EN  = 1;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_IO,
        REGION_NONE
    } region_e;

    // RAM takes precedence so a RAM that reaches the I/O page would shadow it.
    function automatic region_e decode_region(input logic [15:0] addr, input int ram_aw,
                                              input logic [7:0] io_page);
        if ((32'(addr) >> ram_aw) == 32'd0) return REGION_RAM;
        if (addr[15:8] == io_page) return REGION_IO;
        return REGION_NONE;
    endfunction

endpackage

// File: rtl/bus_responder_if.sv
// CPU-bus control signals plus the RX/TX byte streams of bus_responder.
// data_bus stays a plain inout port on the responder; bus_drive reports when it is driven.
interface bus_responder_if;
    logic [15:0] address_bus;
    logic        r;
    logic        w;
    logic        bus_drive;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        irq;

    modport master (
        output address_bus, r, w, rx_data, rx_valid, tx_ready,
        input  bus_drive, rx_ready, tx_data, tx_valid, irq
    );

    modport slave (
        input  address_bus, r, w, rx_data, rx_valid, tx_ready,
        output bus_drive, rx_ready, tx_data, tx_valid, irq
    );
endinterface

// File: rtl/bus_responder_byte_fifo.sv
// byte_fifo: 2^AW-deep byte FIFO, async active-low reset on control only.
// Pushes while full and pops while empty are ignored; dout reads 0x00 when empty.
module byte_fifo #(
    parameter int AW = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == (AW+1)'(2**AW));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/bus_responder.sv
// bus_responder: byte RAM plus one memory-mapped I/O page (STATUS, RXDATA, TXDATA, CTRL).
// Define BUS_RESPONDER_IRQ_EN to store CTRL.irq_en and drive a registered irq.
module bus_responder
    import bus_responder_pkg::*;
#(
    parameter int         RAM_AW  = 12,
    parameter int         FIFO_AW = 3,
    parameter logic [7:0] IO_PAGE = IO_PAGE_DEFAULT
) (
    input  logic           clk,
    input  logic           reset,
    inout  wire  [7:0]     data_bus,
    bus_responder_if.slave bus
);
    region_e    region;
    logic [7:0] offset;
    logic [7:0] ram [2**RAM_AW];
    logic [7:0] rd_data;
    logic       drive;
    logic       rx_push, rx_pop, rx_full, rx_empty;
    logic       tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0] rx_dout, tx_dout;
    logic       ctrl_wr;
    logic       ovf;
    logic       irq_en;

    assign region  = decode_region(bus.address_bus, RAM_AW, IO_PAGE);
    assign offset  = bus.address_bus[7:0];
    assign ctrl_wr = bus.w && region == REGION_IO && offset == IO_CTRL;

    // Illegal r&&w lets the write through but keeps the bus released; reset also releases it.
    assign drive         = bus.r && !bus.w && reset;
    assign bus.bus_drive = drive;
    assign data_bus      = drive ? rd_data : 8'hzz;

    always_ff @(posedge clk) begin
        if (bus.w && region == REGION_RAM) ram[bus.address_bus[RAM_AW-1:0]] <= data_bus;
    end

    always_comb begin
        rd_data = 8'h00;
        case (region)
            REGION_RAM: rd_data = ram[bus.address_bus[RAM_AW-1:0]];
            REGION_IO: begin
                case (offset)
                    IO_STATUS: rd_data = {4'b0, tx_empty, ovf, tx_full, !rx_empty};
                    IO_RXDATA: rd_data = rx_dout;
                    IO_CTRL:   rd_data = {6'b0, irq_en, 1'b0};
                    default:   rd_data = 8'h00;
                endcase
            end
            default: rd_data = 8'h00;
        endcase
    end

    assign bus.rx_ready = !rx_full;
    assign rx_push      = bus.rx_valid && !rx_full;
    assign rx_pop       = bus.r && region == REGION_IO && offset == IO_RXDATA;

    byte_fifo #(.AW(FIFO_AW)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_push),
        .pop   (rx_pop),
        .din   (bus.rx_data),
        .dout  (rx_dout),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign tx_push      = bus.w && region == REGION_IO && offset == IO_TXDATA;
    assign tx_pop       = !tx_empty && bus.tx_ready;
    assign bus.tx_valid = !tx_empty;
    assign bus.tx_data  = tx_dout;

    byte_fifo #(.AW(FIFO_AW)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (data_bus),
        .dout  (tx_dout),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // A lost byte in the same cycle as a clear leaves ovf set.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf <= 1'b0;
        end else if (bus.rx_valid && rx_full) begin
            ovf <= 1'b1;
        end else if (ctrl_wr && data_bus[CTRL_OVF_CLR]) begin
            ovf <= 1'b0;
        end
    end

`ifdef BUS_RESPONDER_IRQ_EN
    logic irq_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_en <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en <= data_bus[CTRL_IRQ_EN];
            irq_q <= irq_en && (!rx_empty || ovf);
        end
    end

    assign bus.irq = irq_q;
`else
    assign irq_en  = 1'b0;
    assign bus.irq = 1'b0;
`endif
endmodule

// File: tb/tb_bus_responder.sv
// Directed self-checking bench for bus_responder: RAM, decode, RX/TX FIFOs, ovf, reset, irq.
module tb_bus_responder;
    import bus_responder_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] cpu_data;
    logic       cpu_drive;
    wire  [7:0] data_bus;
    int         checks = 0;
    int         failures = 0;
    logic [7:0] rd;

    bus_responder_if bif ();

    assign data_bus = cpu_drive ? cpu_data : 8'hzz;

    bus_responder dut (
        .clk      (clk),
        .reset    (reset),
        .data_bus (data_bus),
        .bus      (bif)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        bif.address_bus = addr;
        cpu_data = data;
        cpu_drive = 1'b1;
        bif.w = 1'b1;
        tick();
        bif.w = 1'b0;
        cpu_drive = 1'b0;
    endtask

    task automatic cpu_read(input logic [15:0] addr, output logic [7:0] data);
        bif.address_bus = addr;
        bif.r = 1'b1;
        #3;
        data = data_bus;
        tick();
        bif.r = 1'b0;
    endtask

    task automatic push_rx(input logic [7:0] b);
        bif.rx_data = b;
        bif.rx_valid = 1'b1;
        tick();
        bif.rx_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        cpu_data = 8'h00;
        cpu_drive = 1'b0;
        bif.address_bus = 16'h0000;
        bif.r = 1'b0;
        bif.w = 1'b0;
        bif.rx_data = 8'h00;
        bif.rx_valid = 1'b0;
        bif.tx_ready = 1'b0;
        tick();
        tick();
        check("rst_rx_ready", 16'(bif.rx_ready), 16'h1);
        check("rst_tx_valid", 16'(bif.tx_valid), 16'h0);
        check("rst_tx_data", 16'(bif.tx_data), 16'h00);
        check("rst_irq", 16'(bif.irq), 16'h0);
        bif.r = 1'b1;
        #1;
        check("rst_no_drive", 16'(bif.bus_drive), 16'h0);
        bif.r = 1'b0;
        reset = 1'b1;
        tick();
        cpu_read(16'hFF00, rd);
        check("rst_status", 16'(rd), 16'h08);

        // RAM and address decode
        cpu_write(16'h0FFF, 8'hA5);
        cpu_read(16'h0FFF, rd);
        check("ram_0fff", 16'(rd), 16'hA5);
        cpu_write(16'h0123, 8'h77);
        cpu_read(16'h0123, rd);
        check("ram_0123", 16'(rd), 16'h77);
        cpu_read(16'h2000, rd);
        check("unmapped_2000", 16'(rd), 16'h00);
        cpu_read(16'hFF10, rd);
        check("unmapped_io", 16'(rd), 16'h00);
        #1;
        check("idle_no_drive", 16'(bif.bus_drive), 16'h0);

        // RX fill, overflow, drain, ovf clear
        for (int i = 0; i < 8; i++) push_rx(8'(8'h10 + i));
        check("rx_full_ready", 16'(bif.rx_ready), 16'h0);
        push_rx(8'h18);
        cpu_read(16'hFF00, rd);
        check("status_ovf", 16'(rd), 16'h0D);
        for (int i = 0; i < 8; i++) begin
            cpu_read(16'hFF01, rd);
            check("rx_drain", 16'(rd), 16'(8'h10 + i));
        end
        cpu_read(16'hFF01, rd);
        check("rx_empty_read", 16'(rd), 16'h00);
        cpu_read(16'hFF00, rd);
        check("status_ovf_kept", 16'(rd), 16'h0C);
        cpu_write(16'hFF03, 8'h01);
        cpu_read(16'hFF00, rd);
        check("status_ovf_clr", 16'(rd), 16'h08);

        // TX stream
        cpu_write(16'hFF02, 8'h41);
        cpu_write(16'hFF02, 8'h42);
        check("tx_valid", 16'(bif.tx_valid), 16'h1);
        check("tx_head", 16'(bif.tx_data), 16'h41);
        cpu_read(16'hFF00, rd);
        check("status_tx", 16'(rd), 16'h00);
        bif.tx_ready = 1'b1;
        check("tx_out0", 16'(bif.tx_data), 16'h41);
        tick();
        check("tx_out1_valid", 16'(bif.tx_valid), 16'h1);
        check("tx_out1", 16'(bif.tx_data), 16'h42);
        tick();
        check("tx_drained", 16'(bif.tx_valid), 16'h0);
        bif.tx_ready = 1'b0;
        for (int i = 0; i < 9; i++) cpu_write(16'hFF02, 8'(8'h60 + i));
        cpu_read(16'hFF00, rd);
        check("status_tx_full", 16'(rd), 16'h02);
        bif.tx_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("tx_full_out", 16'(bif.tx_data), 16'(8'h60 + i));
            tick();
        end
        check("tx_ninth_dropped", 16'(bif.tx_valid), 16'h0);
        bif.tx_ready = 1'b0;

        // Asynchronous reset mid-run
        push_rx(8'h21);
        push_rx(8'h22);
        push_rx(8'h23);
        cpu_write(16'hFF02, 8'h33);
        check("pre_rst_tx_valid", 16'(bif.tx_valid), 16'h1);
        check("pre_rst_rx_ready", 16'(bif.rx_ready), 16'h1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_rx_ready", 16'(bif.rx_ready), 16'h1);
        check("mid_rst_tx_valid", 16'(bif.tx_valid), 16'h0);
        check("mid_rst_tx_data", 16'(bif.tx_data), 16'h00);
        tick();
        reset = 1'b1;
        tick();
        cpu_read(16'hFF00, rd);
        check("post_rst_status", 16'(rd), 16'h08);
        cpu_read(16'h0123, rd);
        check("post_rst_ram_0123", 16'(rd), 16'h77);
        cpu_read(16'h0FFF, rd);
        check("post_rst_ram_0fff", 16'(rd), 16'hA5);

        // Same-edge RX pop and push
        push_rx(8'h11);
        cpu_read(16'hFF00, rd);
        check("status_one", 16'(rd), 16'h09);
        bif.rx_data = 8'h99;
        bif.rx_valid = 1'b1;
        cpu_read(16'hFF01, rd);
        bif.rx_valid = 1'b0;
        check("popush_head", 16'(rd), 16'h11);
        cpu_read(16'hFF00, rd);
        check("popush_count", 16'(rd), 16'h09);
        cpu_read(16'hFF01, rd);
        check("popush_next", 16'(rd), 16'h99);
        cpu_read(16'hFF00, rd);
        check("popush_empty", 16'(rd), 16'h08);

        // Interrupt
        cpu_write(16'hFF03, 8'h02);
        cpu_read(16'hFF03, rd);
`ifdef BUS_RESPONDER_IRQ_EN
        check("ctrl_read", 16'(rd), 16'h02);
        check("irq_idle", 16'(bif.irq), 16'h0);
        push_rx(8'h55);
        check("irq_push_edge", 16'(bif.irq), 16'h0);
        tick();
        check("irq_set", 16'(bif.irq), 16'h1);
        cpu_read(16'hFF01, rd);
        check("irq_rx_byte", 16'(rd), 16'h55);
        check("irq_pop_edge", 16'(bif.irq), 16'h1);
        tick();
        check("irq_clear", 16'(bif.irq), 16'h0);
`else
        check("ctrl_read", 16'(rd), 16'h00);
        push_rx(8'h55);
        tick();
        check("irq_off_a", 16'(bif.irq), 16'h0);
        tick();
        check("irq_off_b", 16'(bif.irq), 16'h0);
        cpu_read(16'hFF01, rd);
        check("irq_rx_byte", 16'(rd), 16'h55);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
